mul_pipe_ctrl: RTL and testbench
================================

# mul_pipe_ctrl

Control and result-formatting shell for the 3-stage 32×32 multiplier pipeline (booth partial products | wallace tree | final adder). It accepts LoongArch multiply micro-ops from issue and drives the multiplier's operand, sign and stall inputs. It carries each op's valid/op/tag alongside the datapath and returns the selected 32-bit result to writeback through a valid/ready handshake. It also supports pipeline flush and exposes in-flight destination tags to the scoreboard.

## Interface
- TAG_W, default 5: width of the destination/tag field carried with each op.
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- flush_i  input  1  kill every op in flight and reject this cycle's input.
- in_valid_i  input  1  issue presents an op.
- in_ready_o  output  1  block accepts the op this cycle.
- in_op_i  input  2  operation: 0 = MUL.W (low word), 1 = MULH.W (high word, signed), 2 = MULH.WU (high word, unsigned), 3 = reserved, treated as MUL.W.
- in_a_i, in_b_i  input  32  operands.
- in_tag_i  input  TAG_W  destination tag.
- mul_signed_o  output  1  to multiplier: signed mode.
- mul_x_o, mul_y_o  output  32  to multiplier: operands.
- mul_stall_o  output  1  to multiplier: freeze all pipeline registers.
- mul_res_i  input  64  from multiplier: product of the op in stage 3.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  writeback accepts the result.
- out_res_o  output  32  selected result word.
- out_tag_o  output  TAG_W  tag of the result.
- busy_o  output  1  any op in stage 2 or stage 3.
- s2_valid_o / s2_tag_o, s3_valid_o / s3_tag_o  output  1 / TAG_W  in-flight tags for the scoreboard.

## Operation
- Sideband pipeline: stage 2 registers {v2, op2, tag2} and stage 3 registers {v3, op3, tag3}. They are written under the same condition as the multiplier's stage registers.
- Operand path is combinational:
  - mul_x_o = in_a_i, mul_y_o = in_b_i.
  - mul_signed_o = (in_op_i != 2). MUL.W is computed signed; its low word is identical either way.
- Stall: mul_stall_o = v3 & ~out_ready_i & ~flush_i. When stalled, the multiplier and both sideband stages hold.
- Accept: in_ready_o = ~mul_stall_o & ~flush_i. An op enters when in_valid_i & in_ready_o.
- Advance when ~mul_stall_o:
  - v2 <= in_valid_i & in_ready_o.
  - v3 <= v2.
  - op/tag fields shift together with their valid bits.
  - Bubbles advance like ops; there is no bubble collapse.
- Flush (highest priority): v2 <= 0 and v3 <= 0 on the next edge, regardless of out_ready_i. The input is not accepted. Multiplier data is not cleared; it is simply never marked valid.
- Result: out_valid_o = v3 & ~flush_i; out_tag_o = tag3.
  - out_res_o = mul_res_i[31:0] when op3 is 0 or 3.
  - out_res_o = mul_res_i[63:32] when op3 is 1 or 2.
- Handshake: a result is consumed on the edge where out_valid_o & out_ready_i. Until then out_res_o and out_tag_o hold stable.
- busy_o = v2 | v3. s2_*/s3_* mirror the stage registers directly (not gated by flush).

## Timing
- Latency: an op accepted at edge N (sampled at the end of cycle N) appears on out_valid_o during cycle N+2 when unstalled.
- Throughput: 1 op/cycle with out_ready_i held high.
- in_ready_o and mul_stall_o depend combinationally on out_ready_i and flush_i.
- Back-pressure: if the result waits k cycles, every stage holds for k cycles and in_ready_o is low for the same k cycles.
- Simultaneous out_ready_i and a new input: the pipe advances. A new op enters stage 2 while the stage-3 result retires.
- Reset, applied at any point including mid-operation, takes effect on the next edge:
  - v2 = v3 = 0, op/tag registers = 0.
  - out_valid_o = 0, busy_o = 0, s2/s3 valid = 0.
  - mul_stall_o = 0, in_ready_o = 1 while flush_i = 0.
  - The multiplier is reset from the same rst_n.

## Test plan
- Reset, then one MUL.W with a = 0xFFFFFFFF (−1), b = 2, tag 3, out_ready_i = 1 → cycle N+2: out_valid_o = 1, out_res_o = 0xFFFFFFFE, out_tag_o = 3. All later cycles: out_valid_o = 0, busy_o = 0.
- MULH.W a = 0x80000000, b = 0x80000000 → out_res_o = 0x40000000. MULH.WU with the same operands → 0x40000000. MULH.W a = −1, b = 1 → 0xFFFFFFFF. MULH.WU a = 0xFFFFFFFF, b = 0xFFFFFFFF → 0xFFFFFFFE.
- Back-to-back stream of 8 ops, tags 0..7, out_ready_i = 1 → 8 consecutive valid results in issue order, each with the correct value. in_ready_o stays 1 throughout.
- Same stream with out_ready_i = 0 for 3 cycles while tag 2 is at the output → out_res_o and out_tag_o hold for 3 cycles and in_ready_o = 0 during them. After release there is no loss or duplication, and the order stays 0..7.
- flush_i pulsed for one cycle with ops in stage 2 and stage 3 and a valid input present:
  - In the flush cycle, in_ready_o = 0 and out_valid_o = 0.
  - Next cycle: v2 = v3 = 0 and busy_o = 0.
  - An op issued afterwards completes normally with latency 2.
- rst_n asserted for one cycle mid-stream with out_ready_i = 0 → the next cycle shows all valids 0, in_ready_o = 1 and out_valid_o = 0.

Source files
------------

// File: rtl/mul_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// mul_pipe_ctrl
//
// Control and result-formatting shell around a 3-stage 32x32 multiplier
// (booth partial products | wallace tree | final adder). Issue hands in
// LoongArch multiply micro-ops; this block drives the multiplier's operand,
// sign and stall inputs. It also carries valid/op/tag for each op in a
// sideband pipeline that stays in lock-step with the multiplier's stage
// registers. The selected 32-bit result is returned to writeback through a
// valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush_i               kill everything in flight, refuse this cycle's input
//   in_valid_i/in_ready_o issue handshake
//   in_op_i               0 MUL.W, 1 MULH.W, 2 MULH.WU, 3 reserved (as MUL.W)
//   in_a_i, in_b_i        operands
//   in_tag_i              destination tag
//   mul_signed_o          multiplier signed mode
//   mul_x_o, mul_y_o      multiplier operands
//   mul_stall_o           freeze all multiplier pipeline registers
//   mul_res_i             64-bit product of the op in stage 3
//   out_valid_o/out_ready_i  writeback handshake
//   out_res_o, out_tag_o  selected result word and its tag
//   busy_o                any op in stage 2 or stage 3
//   s2_*/s3_*             raw stage registers for the scoreboard
// -----------------------------------------------------------------------------
module mul_pipe_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,

  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,

  output logic             mul_signed_o,
  output logic [31:0]      mul_x_o,
  output logic [31:0]      mul_y_o,
  output logic             mul_stall_o,
  input  logic [63:0]      mul_res_i,

  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [TAG_W-1:0] out_tag_o,

  output logic             busy_o,
  output logic             s2_valid_o,
  output logic [TAG_W-1:0] s2_tag_o,
  output logic             s3_valid_o,
  output logic [TAG_W-1:0] s3_tag_o
);

  localparam logic [1:0] OP_MULHWU = 2'd2;

  // Sideband stage registers
  logic             r_v2;
  logic [1:0]       r_op2;
  logic [TAG_W-1:0] r_tag2;
  logic             r_v3;
  logic [1:0]       r_op3;
  logic [TAG_W-1:0] r_tag3;

  logic w_stall;
  logic w_accept;
  logic w_sel_high;

  // The pipe only freezes when a finished result is waiting on writeback.
  // A flush overrides the stall so the kill always lands on the next edge.
  assign w_stall  = r_v3 & ~out_ready_i & ~flush_i;
  assign w_accept = in_valid_i & in_ready_o;

  // Operands go straight to the multiplier's first stage. MUL.W is run in
  // signed mode: the low word of the product is the same either way.
  assign mul_x_o      = in_a_i;
  assign mul_y_o      = in_b_i;
  assign mul_signed_o = (in_op_i != OP_MULHWU);
  assign mul_stall_o  = w_stall;

  assign in_ready_o = ~w_stall & ~flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_op2  <= 2'd0;
      r_tag2 <= '0;
      r_v3   <= 1'b0;
      r_op3  <= 2'd0;
      r_tag3 <= '0;
    end else if (flush_i) begin
      // Only the valid bits are cleared; the multiplier's data is left to
      // drain and is simply never reported.
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (!w_stall) begin
      // Bubbles advance like ops: no collapse, fixed 2-edge latency.
      r_v2   <= w_accept;
      r_op2  <= in_op_i;
      r_tag2 <= in_tag_i;
      r_v3   <= r_v2;
      r_op3  <= r_op2;
      r_tag3 <= r_tag2;
    end
  end

  // High word for MULH.W (01) and MULH.WU (10); low word for MUL.W (00)
  // and the reserved code (11).
  assign w_sel_high = r_op3[1] ^ r_op3[0];

  assign out_valid_o = r_v3 & ~flush_i;
  assign out_tag_o   = r_tag3;
  assign out_res_o   = w_sel_high ? mul_res_i[63:32] : mul_res_i[31:0];

  assign busy_o     = r_v2 | r_v3;
  assign s2_valid_o = r_v2;
  assign s2_tag_o   = r_tag2;
  assign s3_valid_o = r_v3;
  assign s3_tag_o   = r_tag3;

endmodule

// File: tb/tb_mul_pipe_ctrl.sv
module tb_mul_pipe_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       in_op_i;
  logic [31:0]      in_a_i;
  logic [31:0]      in_b_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             mul_signed_o;
  logic [31:0]      mul_x_o;
  logic [31:0]      mul_y_o;
  logic             mul_stall_o;
  logic [63:0]      mul_res_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [31:0]      out_res_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             busy_o;
  logic             s2_valid_o;
  logic [TAG_W-1:0] s2_tag_o;
  logic             s3_valid_o;
  logic [TAG_W-1:0] s3_tag_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_pipe_ctrl #(.TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_op_i      (in_op_i),
    .in_a_i       (in_a_i),
    .in_b_i       (in_b_i),
    .in_tag_i     (in_tag_i),
    .mul_signed_o (mul_signed_o),
    .mul_x_o      (mul_x_o),
    .mul_y_o      (mul_y_o),
    .mul_stall_o  (mul_stall_o),
    .mul_res_i    (mul_res_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_res_o    (out_res_o),
    .out_tag_o    (out_tag_o),
    .busy_o       (busy_o),
    .s2_valid_o   (s2_valid_o),
    .s2_tag_o     (s2_tag_o),
    .s3_valid_o   (s3_valid_o),
    .s3_tag_o     (s3_tag_o)
  );

  // Stand-in for the external 3-stage multiplier: product computed in
  // stage 1, registered into stage 2, then stage 3; all held by stall.
  logic [63:0] m_x, m_y, m_prod, m_p2, m_p3;
  assign m_x    = mul_signed_o ? {{32{mul_x_o[31]}}, mul_x_o} : {32'd0, mul_x_o};
  assign m_y    = mul_signed_o ? {{32{mul_y_o[31]}}, mul_y_o} : {32'd0, mul_y_o};
  assign m_prod = m_x * m_y;
  assign mul_res_i = m_p3;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_p2 <= 64'd0;
      m_p3 <= 64'd0;
    end else if (!mul_stall_o) begin
      m_p2 <= m_prod;
      m_p3 <= m_p2;
    end
  end

  // Stream stimulus table and hand-computed expected results
  logic [1:0]  st_op  [8];
  logic [31:0] st_a   [8];
  logic [31:0] st_b   [8];
  logic [31:0] st_exp [8];

  // Stream capture
  logic [31:0]      got_res [16];
  logic [TAG_W-1:0] got_tag [16];
  int               got_cyc [16];
  int               n_got;
  int               n_ready_low;
  int               n_held;
  int               n_held_good;
  int               n_stall;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    in_op_i    = 2'd0;
    in_a_i     = 32'd0;
    in_b_i     = 32'd0;
    in_tag_i   = '0;
    out_ready_i = 1'b1;
  endtask

  // Issues one op and waits (bounded) for its result. lat = -1 on timeout.
  task automatic issue_one(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           output logic [31:0] res, output logic [TAG_W-1:0] tg,
                           output int lat);
    lat = -1;
    res = 32'd0;
    tg  = '0;
    @(negedge clk);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_op_i     = op;
    in_a_i      = a;
    in_b_i      = b;
    in_tag_i    = tag;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid_i = 1'b0;
      #1;
      if (out_valid_o) begin
        lat = k;
        res = out_res_o;
        tg  = out_tag_o;
        break;
      end
    end
  endtask

  // Streams the 8-op table; holds out_ready_i low for stall_n cycles while
  // tag 2 sits at the output. Records what came out.
  task automatic run_stream(input int stall_n);
    int idx;
    idx = 0;
    n_got = 0;
    n_ready_low = 0;
    n_held = 0;
    n_held_good = 0;
    n_stall = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      #1;
      if (out_valid_o && out_tag_o == 5'd2 && n_held < stall_n) begin
        out_ready_i = 1'b0;
        n_held++;
      end else begin
        out_ready_i = 1'b1;
      end
      if (idx < 8) begin
        in_valid_i = 1'b1;
        in_op_i    = st_op[idx];
        in_a_i     = st_a[idx];
        in_b_i     = st_b[idx];
        in_tag_i   = idx[TAG_W-1:0];
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (!in_ready_o) n_ready_low++;
      if (mul_stall_o) n_stall++;
      if (out_valid_o) begin
        if (!out_ready_i) begin
          if (out_res_o === st_exp[2] && out_tag_o === 5'd2) n_held_good++;
        end else if (n_got < 16) begin
          got_res[n_got] = out_res_o;
          got_tag[n_got] = out_tag_o;
          got_cyc[n_got] = cyc;
          n_got++;
        end
      end
      if (in_valid_i && in_ready_o) idx++;
      if (idx == 8 && n_got >= 8) break;
    end
    // let any stray extra result show up
    @(negedge clk);
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    if (out_valid_o && n_got < 16) begin
      got_res[n_got] = out_res_o;
      got_tag[n_got] = out_tag_o;
      got_cyc[n_got] = 99;
      n_got++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || s2_valid_o !== 1'b0 || s3_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valids: out_valid=%b busy=%b s2=%b s3=%b, required all 0",
               out_valid_o, busy_o, s2_valid_o, s3_valid_o);
    end
    n_tests++;
    if (in_ready_o !== 1'b1 || mul_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b stall=%b, required 1/0", in_ready_o, mul_stall_o);
    end
    n_tests++;
    if (s2_tag_o !== 5'd0 || s3_tag_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_tags: s2_tag=%0d s3_tag=%0d, required 0/0", s2_tag_o, s3_tag_o);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_mul_w();
    logic [31:0]      res;
    logic [TAG_W-1:0] tg;
    int               lat;
    issue_one(2'd0, 32'hFFFFFFFF, 32'd2, 5'd3, res, tg, lat);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL mulw_latency: got %0d, required 2", lat);
    end
    n_tests++;
    if (res !== 32'hFFFFFFFE || tg !== 5'd3) begin
      n_fail++;
      $display("FAIL mulw_result: got res=%h tag=%0d, required res=fffffffe tag=3", res, tg);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL mulw_after: cycle %0d out_valid=%b busy=%b, required 0/0", k, out_valid_o, busy_o);
      end
    end
    $display("[TB] MUL.W -1*2 res=%h tag=%0d lat=%0d", res, tg, lat);
  endtask

  task automatic test_mulh();
    logic [1:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] exs [4];
    logic [31:0]      res;
    logic [TAG_W-1:0] tg;
    int               lat;
    ops[0] = 2'd1; as[0] = 32'h80000000; bs[0] = 32'h80000000; exs[0] = 32'h40000000;
    ops[1] = 2'd2; as[1] = 32'h80000000; bs[1] = 32'h80000000; exs[1] = 32'h40000000;
    ops[2] = 2'd1; as[2] = 32'hFFFFFFFF; bs[2] = 32'd1;        exs[2] = 32'hFFFFFFFF;
    ops[3] = 2'd2; as[3] = 32'hFFFFFFFF; bs[3] = 32'hFFFFFFFF; exs[3] = 32'hFFFFFFFE;
    for (int i = 0; i < 4; i++) begin
      issue_one(ops[i], as[i], bs[i], 5'(i + 8), res, tg, lat);
      n_tests++;
      if (lat !== 2 || res !== exs[i] || tg !== 5'(i + 8)) begin
        n_fail++;
        $display("FAIL mulh_%0d: got res=%h tag=%0d lat=%0d, required res=%h tag=%0d lat=2",
                 i, res, tg, lat, exs[i], i + 8);
      end
      $display("[TB] op=%0d a=%h b=%h res=%h tag=%0d", ops[i], as[i], bs[i], res, tg);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(0);
    n_tests++;
    if (n_got !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 8", n_got);
    end
    for (int i = 0; i < 8 && i < n_got; i++) begin
      n_tests++;
      if (got_res[i] !== st_exp[i] || got_tag[i] !== 5'(i)) begin
        n_fail++;
        $display("FAIL b2b_result_%0d: got res=%h tag=%0d, required res=%h tag=%0d",
                 i, got_res[i], got_tag[i], st_exp[i], i);
      end
      $display("[TB] b2b tag=%0d res=%h cyc=%0d", got_tag[i], got_res[i], got_cyc[i]);
    end
    n_tests++;
    if (n_got >= 8 && got_cyc[7] - got_cyc[0] !== 7) begin
      n_fail++;
      $display("FAIL b2b_consecutive: span %0d cycles, required 7", got_cyc[7] - got_cyc[0]);
    end
    n_tests++;
    if (n_ready_low !== 0) begin
      n_fail++;
      $display("FAIL b2b_in_ready: low for %0d cycles, required 0", n_ready_low);
    end
  endtask

  task automatic test_backpressure();
    run_stream(3);
    n_tests++;
    if (n_got !== 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 8", n_got);
    end
    for (int i = 0; i < 8 && i < n_got; i++) begin
      n_tests++;
      if (got_res[i] !== st_exp[i] || got_tag[i] !== 5'(i)) begin
        n_fail++;
        $display("FAIL bp_result_%0d: got res=%h tag=%0d, required res=%h tag=%0d",
                 i, got_res[i], got_tag[i], st_exp[i], i);
      end
      $display("[TB] bp tag=%0d res=%h cyc=%0d", got_tag[i], got_res[i], got_cyc[i]);
    end
    n_tests++;
    if (n_held_good !== 3) begin
      n_fail++;
      $display("FAIL bp_hold: stable tag 2 result for %0d stalled cycles, required 3", n_held_good);
    end
    n_tests++;
    if (n_ready_low !== 3 || n_stall !== 3) begin
      n_fail++;
      $display("FAIL bp_in_ready: in_ready low %0d, stall %0d cycles, required 3/3", n_ready_low, n_stall);
    end
    n_tests++;
    if (n_got >= 8 && got_cyc[7] - got_cyc[0] !== 10) begin
      n_fail++;
      $display("FAIL bp_span: span %0d cycles, required 10", got_cyc[7] - got_cyc[0]);
    end
  endtask

  task automatic test_flush();
    logic [31:0]      res;
    logic [TAG_W-1:0] tg;
    int               lat;
    @(negedge clk);
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_op_i = 2'd0; in_a_i = 32'd2; in_b_i = 32'd3; in_tag_i = 5'd10;
    @(negedge clk);
    in_tag_i = 5'd11; in_a_i = 32'd4; in_b_i = 32'd5;
    @(negedge clk);
    flush_i = 1'b1;
    in_tag_i = 5'd12; in_a_i = 32'd9; in_b_i = 32'd9;
    #1;
    n_tests++;
    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_cycle: in_ready=%b out_valid=%b, required 0/0", in_ready_o, out_valid_o);
    end
    n_tests++;
    if (s2_valid_o !== 1'b1 || s3_valid_o !== 1'b1 || s2_tag_o !== 5'd11 || s3_tag_o !== 5'd10) begin
      n_fail++;
      $display("FAIL flush_stages: s2=%b/%0d s3=%b/%0d, required 1/11 1/10",
               s2_valid_o, s2_tag_o, s3_valid_o, s3_tag_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    n_tests++;
    if (s2_valid_o !== 1'b0 || s3_valid_o !== 1'b0 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: s2=%b s3=%b busy=%b out_valid=%b, required all 0",
               s2_valid_o, s3_valid_o, busy_o, out_valid_o);
    end
    issue_one(2'd0, 32'd6, 32'd7, 5'd13, res, tg, lat);
    n_tests++;
    if (lat !== 2 || res !== 32'd42 || tg !== 5'd13) begin
      n_fail++;
      $display("FAIL flush_next_op: got res=%h tag=%0d lat=%0d, required res=0000002a tag=13 lat=2",
               res, tg, lat);
    end
    $display("[TB] flush then op res=%h tag=%0d lat=%0d", res, tg, lat);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_op_i = 2'd0; in_a_i = 32'd3; in_b_i = 32'd3; in_tag_i = 5'd20;
    @(negedge clk);
    in_tag_i = 5'd21;
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    n_tests++;
    if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || out_tag_o !== 5'd20) begin
      n_fail++;
      $display("FAIL rstmid_pre: out_valid=%b in_ready=%b tag=%0d, required 1/0/20",
               out_valid_o, in_ready_o, out_tag_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (s2_valid_o !== 1'b0 || s3_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || mul_stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_post: s2=%b s3=%b busy=%b out_valid=%b in_ready=%b stall=%b, required 0 0 0 0 1 0",
               s2_valid_o, s3_valid_o, busy_o, out_valid_o, in_ready_o, mul_stall_o);
    end
    $display("[TB] reset mid-stream checked");
    out_ready_i = 1'b1;
  endtask

  initial begin
    st_op[0] = 2'd0; st_a[0] = 32'd3;         st_b[0] = 32'd5;         st_exp[0] = 32'h0000000F;
    st_op[1] = 2'd1; st_a[1] = 32'h80000000;  st_b[1] = 32'd2;         st_exp[1] = 32'hFFFFFFFF;
    st_op[2] = 2'd2; st_a[2] = 32'h80000000;  st_b[2] = 32'd2;         st_exp[2] = 32'h00000001;
    st_op[3] = 2'd3; st_a[3] = 32'h00010000;  st_b[3] = 32'h00010000;  st_exp[3] = 32'h00000000;
    st_op[4] = 2'd0; st_a[4] = 32'hFFFFFFFF;  st_b[4] = 32'hFFFFFFFF;  st_exp[4] = 32'h00000001;
    st_op[5] = 2'd1; st_a[5] = 32'h7FFFFFFF;  st_b[5] = 32'h7FFFFFFF;  st_exp[5] = 32'h3FFFFFFF;
    st_op[6] = 2'd2; st_a[6] = 32'hFFFFFFFF;  st_b[6] = 32'd2;         st_exp[6] = 32'h00000001;
    st_op[7] = 2'd1; st_a[7] = 32'hFFFFFFFF;  st_b[7] = 32'd2;         st_exp[7] = 32'hFFFFFFFF;

    test_reset();
    test_mul_w();
    test_mulh();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
